// File: rtl/dts_ctrl_pkg.sv
// Shared types and default timing for the DTS deformatter control-bus sequencer.
package dts_ctrl_pkg;

  localparam int unsigned DEF_N_CHAN    = 12;
  localparam int unsigned DEF_SETUP_CYC = 4;
  localparam int unsigned DEF_STRB_CYC  = 8;
  localparam int unsigned DEF_HOLD_CYC  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dts_ctrl_lowbit.sv
// Lowest-set-bit selector: one-hot, index and non-empty flag of a channel mask.
module dts_ctrl_lowbit #(
  parameter int unsigned N = 12,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  onehot_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  logic found;

  always_comb begin
    onehot_c = '0;
    idx_c    = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i] && !found) begin
        found       = 1'b1;
        onehot_c[i] = 1'b1;
        idx_c       = IW'(i);
      end
    end
    any_c = found;
  end

endmodule

// File: rtl/dts_ctrl_sequencer.sv
// Drives the shared deformatter control bus: broadcast writes, per-channel reads
// with programmable setup/strobe/hold, one response per command.
module dts_ctrl_sequencer
  import dts_ctrl_pkg::*;
#(
  parameter int unsigned N_CHAN    = DEF_N_CHAN,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned STRB_CYC  = DEF_STRB_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [N_CHAN-1:0]   cmd_mask,
  input  logic [7:0]          cmd_addr,
  input  logic [7:0]          cmd_data,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [8*N_CHAN-1:0] rsp_data,
  input  logic                unmute_i,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic [7:0]          addr_out,
  output logic [N_CHAN-1:0]   cs_out,
  output logic                wrst_out,
  output logic                rdst_out,
  output logic                unmute_out
);

  localparam int unsigned IW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int unsigned CW = $clog2(max3(SETUP_CYC, STRB_CYC, HOLD_CYC) + 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [N_CHAN-1:0]   rem_q, rem_d;
  logic [IW-1:0]       idx_q, idx_d;

  logic                cmd_ready_d, rsp_valid_d, rsp_err_d, wrst_d, rdst_d;
  logic [8*N_CHAN-1:0] rsp_data_d;
  logic [7:0]          data_d, addr_d;
  logic [N_CHAN-1:0]   cs_d;

  logic [N_CHAN-1:0]   lb_mask, lb_onehot;
  logic [IW-1:0]       lb_idx;
  logic                lb_any;

  // In IDLE pick from the incoming mask; otherwise the next channel after the current one.
  assign lb_mask = (state_q == ST_IDLE) ? cmd_mask : (rem_q & ~cs_out);

  dts_ctrl_lowbit #(.N(N_CHAN)) u_lowbit (
    .mask     (lb_mask),
    .onehot_c (lb_onehot),
    .idx_c    (lb_idx),
    .any_c    (lb_any)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data;
    data_d      = data_out;
    addr_d      = addr_out;
    cs_d        = cs_out;
    wrst_d      = wrst_out;
    rdst_d      = rdst_out;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          write_d    = cmd_write;
          rem_d      = cmd_mask;
          rsp_data_d = '0;
          if (cmd_mask == '0) begin
            state_d     = ST_DONE;
            cnt_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = CW'(SETUP_CYC - 1);
            addr_d  = cmd_addr;
            cs_d    = cmd_write ? cmd_mask : lb_onehot;
            data_d  = cmd_write ? cmd_data : 8'h00;
            idx_d   = lb_idx;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CW'(STRB_CYC - 1);
          wrst_d  = write_q;
          rdst_d  = !write_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
          wrst_d  = 1'b0;
          rdst_d  = 1'b0;
          if (!write_q) begin
            for (int unsigned i = 0; i < N_CHAN; i++) begin
              if (idx_q == IW'(i)) rsp_data_d[8*i +: 8] = data_in;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          rem_d = rem_q & ~cs_out;
          if (!write_q && lb_any) begin
            state_d = ST_SETUP;
            cnt_d   = CW'(SETUP_CYC - 1);
            cs_d    = lb_onehot;
            idx_d   = lb_idx;
          end else begin
            state_d     = ST_DONE;
            cnt_d       = '0;
            rsp_valid_d = 1'b1;
            cs_d        = '0;
            addr_d      = 8'h00;
            data_d      = 8'h00;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      rem_q      <= '0;
      idx_q      <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      data_out   <= 8'h00;
      addr_out   <= 8'h00;
      cs_out     <= '0;
      wrst_out   <= 1'b0;
      rdst_out   <= 1'b0;
      unmute_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      cmd_ready  <= cmd_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_err    <= rsp_err_d;
      rsp_data   <= rsp_data_d;
      data_out   <= data_d;
      addr_out   <= addr_d;
      cs_out     <= cs_d;
      wrst_out   <= wrst_d;
      rdst_out   <= rdst_d;
      unmute_out <= unmute_i;
    end
  end

endmodule

// File: tb/tb_dts_ctrl_sequencer.sv
// Directed self-checking bench for dts_ctrl_sequencer with default timing (S=4, T=8, H=4).
module tb_dts_ctrl_sequencer;

  localparam int unsigned N = 12;

  logic           wb_clk_i = 1'b0;
  logic           wb_rst_i;
  logic           cmd_valid, cmd_ready, cmd_write;
  logic [N-1:0]   cmd_mask;
  logic [7:0]     cmd_addr, cmd_data;
  logic           rsp_valid, rsp_err;
  logic [8*N-1:0] rsp_data;
  logic           unmute_i, unmute_out;
  logic [7:0]     data_in, data_out, addr_out;
  logic [N-1:0]   cs_out;
  logic           wrst_out, rdst_out;

  int n_checks = 0;
  int n_pass   = 0;

  dts_ctrl_sequencer dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_mask   (cmd_mask),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_data   (rsp_data),
    .unmute_i   (unmute_i),
    .data_in    (data_in),
    .data_out   (data_out),
    .addr_out   (addr_out),
    .cs_out     (cs_out),
    .wrst_out   (wrst_out),
    .rdst_out   (rdst_out),
    .unmute_out (unmute_out)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Deformatter model: selected channel i answers 0x10+i while read strobe is high.
  always_comb begin
    data_in = 8'h00;
    if (rdst_out) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (cs_out[i]) data_in = 8'h10 + 8'(i);
      end
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input int cyc, input logic [95:0] obs,
                       input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic issue(input logic w, input logic [N-1:0] m, input logic [7:0] a,
                       input logic [7:0] d);
    check("ready_before_accept", 0, 96'(cmd_ready), 96'h1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_mask  = m;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag, input int cyc);
    check({tag, "_ready"}, cyc, 96'(cmd_ready), 96'h0);
    check({tag, "_rsp_valid"}, cyc, 96'(rsp_valid), 96'h0);
    check({tag, "_rsp_err"}, cyc, 96'(rsp_err), 96'h0);
    check({tag, "_rsp_data"}, cyc, 96'(rsp_data), 96'h0);
    check({tag, "_data_out"}, cyc, 96'(data_out), 96'h0);
    check({tag, "_addr_out"}, cyc, 96'(addr_out), 96'h0);
    check({tag, "_cs_out"}, cyc, 96'(cs_out), 96'h0);
    check({tag, "_wrst"}, cyc, 96'(wrst_out), 96'h0);
    check({tag, "_rdst"}, cyc, 96'(rdst_out), 96'h0);
    check({tag, "_unmute"}, cyc, 96'(unmute_out), 96'h0);
  endtask

  initial begin
    logic [8*N-1:0] exp_rd;
    logic [N-1:0]   ch_oh [3];
    logic [15:0]    upat;
    logic           u_prev;
    int             j, ph;

    exp_rd          = '0;
    exp_rd[0 +: 8]  = 8'h10;
    exp_rd[40 +: 8] = 8'h15;
    exp_rd[88 +: 8] = 8'h1B;
    ch_oh[0] = 12'h001;
    ch_oh[1] = 12'h020;
    ch_oh[2] = 12'h800;
    upat     = 16'hB38D;

    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_mask  = '0;
    cmd_addr  = 8'h00;
    cmd_data  = 8'h00;
    unmute_i  = 1'b1;

    // Reset: everything low, unmute_out held 0 even with unmute_i high.
    tick(); tick(); tick();
    check_all_zero("reset", 0);
    unmute_i = 1'b0;
    wb_rst_i = 1'b0;
    tick();
    check("ready_after_release", 0, 96'(cmd_ready), 96'h1);

    // Broadcast write.
    issue(1'b1, 12'hFFF, 8'h12, 8'hA5);
    for (int c = 1; c <= 18; c++) begin
      check("wr_cs", c, 96'(cs_out), (c <= 16) ? 96'hFFF : 96'h0);
      check("wr_addr", c, 96'(addr_out), (c <= 16) ? 96'h12 : 96'h0);
      check("wr_data", c, 96'(data_out), (c <= 16) ? 96'hA5 : 96'h0);
      check("wr_wrst", c, 96'(wrst_out), 96'(c >= 5 && c <= 12));
      check("wr_rdst", c, 96'(rdst_out), 96'h0);
      check("wr_rsp_valid", c, 96'(rsp_valid), 96'(c == 17));
      check("wr_ready", c, 96'(cmd_ready), 96'(c >= 18));
      if (c == 17) check("wr_rsp_err", c, 96'(rsp_err), 96'h0);
      tick();
    end

    // Three-channel read: ch0, ch5, ch11 in order.
    issue(1'b0, 12'h821, 8'h03, 8'hFF);
    for (int c = 1; c <= 50; c++) begin
      j  = (c - 1) / 16;
      ph = (c - 1) % 16 + 1;
      check("rd_cs", c, 96'(cs_out), (c <= 48) ? 96'(ch_oh[j]) : 96'h0);
      check("rd_addr", c, 96'(addr_out), (c <= 48) ? 96'h03 : 96'h0);
      check("rd_data_out", c, 96'(data_out), 96'h0);
      check("rd_rdst", c, 96'(rdst_out), 96'(c <= 48 && ph >= 5 && ph <= 12));
      check("rd_wrst", c, 96'(wrst_out), 96'h0);
      check("rd_rsp_valid", c, 96'(rsp_valid), 96'(c == 49));
      if (c == 49) check("rd_rsp_err", c, 96'(rsp_err), 96'h0);
      if (c >= 49) check("rd_rsp_data", c, 96'(rsp_data), 96'(exp_rd));
      tick();
    end

    // Zero mask: immediate error response, no bus activity, rsp_data cleared.
    issue(1'b0, 12'h000, 8'h44, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      check("zm_rsp_valid", c, 96'(rsp_valid), 96'(c == 1));
      check("zm_rsp_err", c, 96'(rsp_err), 96'(c == 1));
      check("zm_rsp_data", c, 96'(rsp_data), 96'h0);
      check("zm_cs", c, 96'(cs_out), 96'h0);
      check("zm_addr", c, 96'(addr_out), 96'h0);
      check("zm_rdst", c, 96'(rdst_out), 96'h0);
      check("zm_ready", c, 96'(cmd_ready), 96'(c >= 2));
      tick();
    end

    // Reset during the strobe of a read.
    issue(1'b0, 12'h002, 8'h07, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) begin
        check("rr_rdst_pre", c, 96'(rdst_out), 96'h1);
        check("rr_cs_pre", c, 96'(cs_out), 96'h002);
      end else begin
        tick();
      end
    end
    wb_rst_i = 1'b1;
    tick();
    check_all_zero("rr_reset", 7);
    wb_rst_i = 1'b0;
    tick();
    check("rr_ready_release", 8, 96'(cmd_ready), 96'h1);
    for (int c = 8; c <= 11; c++) begin
      check("rr_no_rsp", c, 96'(rsp_valid), 96'h0);
      check("rr_cs_idle", c, 96'(cs_out), 96'h0);
      tick();
    end

    // Fresh write after the aborted read completes normally.
    issue(1'b1, 12'h00F, 8'h55, 8'h3C);
    for (int c = 1; c <= 18; c++) begin
      check("pw_cs", c, 96'(cs_out), (c <= 16) ? 96'h00F : 96'h0);
      check("pw_wrst", c, 96'(wrst_out), 96'(c >= 5 && c <= 12));
      check("pw_rsp_valid", c, 96'(rsp_valid), 96'(c == 17));
      if (c == 1) check("pw_data", c, 96'(data_out), 96'h3C);
      if (c == 1) check("pw_addr", c, 96'(addr_out), 96'h55);
      tick();
    end

    // Back-to-back commands with cmd_valid held; unmute mirrored throughout.
    check("b2b_ready_first", 0, 96'(cmd_ready), 96'h1);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_mask  = 12'h001;
    cmd_addr  = 8'h20;
    cmd_data  = 8'h11;
    unmute_i  = upat[0];
    u_prev    = unmute_i;
    tick();
    cmd_mask  = 12'h100;
    cmd_addr  = 8'h21;
    cmd_data  = 8'h22;
    for (int c = 1; c <= 37; c++) begin
      check("b2b_unmute", c, 96'(unmute_out), 96'(u_prev));
      check("b2b_rsp_valid", c, 96'(rsp_valid), 96'(c == 17 || c == 35));
      check("b2b_ready", c, 96'(cmd_ready), 96'(c == 18 || c >= 36));
      check("b2b_cs", c, 96'(cs_out),
            (c <= 16) ? 96'h001 : ((c >= 19 && c <= 34) ? 96'h100 : 96'h0));
      if (c == 19) begin
        check("b2b_addr2", c, 96'(addr_out), 96'h21);
        check("b2b_data2", c, 96'(data_out), 96'h22);
        cmd_valid = 1'b0;
      end
      unmute_i = upat[c % 16];
      u_prev   = unmute_i;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dts_ctrl_sequencer.md
# dts_ctrl_sequencer

Sequencer for the shared control bus of the 12 DTS deformatters on one VLA antenna. It accepts single register-access commands (write or read, with a channel mask) and drives address, data, chip-select and write/read strobes with programmable setup, strobe and hold times. Writes broadcast to all masked channels at once; reads visit the masked channels one at a time in ascending order and return all bytes in one response. It sits between the software register block and the deformatter `data_in`/`data_out`/`addr_out`/`cs_out`/`wrst_out`/`rdst_out`/`unmute_out` pins.

## Interface
Parameters:
- `N_CHAN`, 12, number of deformatters (cs width).
- `SETUP_CYC`, 4, cycles address/data/cs stable before strobe (≥1).
- `STRB_CYC`, 8, cycles strobe held high (≥1).
- `HOLD_CYC`, 4, cycles address/data/cs held after strobe (≥1).

Ports (one clock; reset is synchronous and active-high):
- `wb_clk_i` in 1: clock, same domain as the deformatter control bus.
- `wb_rst_i` in 1: synchronous active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE and not in reset.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_mask` in N_CHAN: channels addressed.
- `cmd_addr` in 8: deformatter register address.
- `cmd_data` in 8: write byte (ignored for reads).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_err` out 1: valid with `rsp_valid`; 1 if `cmd_mask` was zero.
- `rsp_data` out 8*N_CHAN: read bytes, slot i = channel i; unvisited slots 0.
- `unmute_i` in 1: requested unmute level.
- `data_in` in 8: deformatter read bus.
- `data_out` out 8, `addr_out` out 8, `cs_out` out N_CHAN, `wrst_out` out 1, `rdst_out` out 1, `unmute_out` out 1: deformatter control bus, all registered.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: on `cmd_valid && cmd_ready`, latch command, remaining-mask := `cmd_mask`. Mask zero → DONE with `rsp_err`=1, no bus activity. Otherwise → SETUP.
- Write: `cs_out` = full latched mask; `data_out` = `cmd_data`; `wrst_out` high in STROBE.
- Read: `cs_out` = one-hot of lowest set bit of remaining mask; `data_out` = 0; `rdst_out` high in STROBE; `data_in` registered into that channel's `rsp_data` slot on the last STROBE cycle; bit cleared from remaining mask at end of HOLD.
- SETUP→STROBE after SETUP_CYC, STROBE→HOLD after STRB_CYC, HOLD→SETUP (read, bits remain) or DONE (otherwise) after HOLD_CYC.
- `addr_out`, `cs_out` constant through SETUP/STROBE/HOLD of one access; `wrst_out`, `rdst_out` never both high.
- DONE: `rsp_valid`=1 for one cycle, `cs_out`,`addr_out`,`data_out` := 0, → IDLE.
- `rsp_data` cleared at command accept; holds value after DONE until next accept.
- `unmute_out` = `unmute_i` registered one cycle, independent of transactions.
- Single cycle counter, width clog2(max(SETUP_CYC,STRB_CYC,HOLD_CYC)+1), reloaded on each state entry.

## Timing
- Accept at cycle 0. Write: SETUP cycles 1..S, STROBE S+1..S+T, HOLD S+T+1..S+T+H, `rsp_valid` at S+T+H+1 (17 with defaults). `cmd_ready` high again at S+T+H+2.
- Read of k channels: `rsp_valid` at k*(S+T+H)+1.
- Zero-mask command: `rsp_valid`,`rsp_err` at cycle 1.
- `cmd_valid` while busy: ignored, command must be held by requester.
- Reset values: `cmd_ready` 0 during reset (1 cycle after release), `rsp_valid` 0, `rsp_err` 0, `rsp_data` 0, `data_out` 0, `addr_out` 0, `cs_out` 0, `wrst_out` 0, `rdst_out` 0, `unmute_out` 0.
- Reset mid-operation: all outputs to reset values at the next edge, state IDLE, in-flight command dropped, no `rsp_valid`.

## Structure
- Package `dts_ctrl_pkg`: state enum, `N_CHAN`, default timing constants.
- Sub-module `dts_ctrl_lowbit`: lowest-set-bit one-hot and index from an N_CHAN mask, used for read channel selection.

## Test plan
- Write addr 0x12 data 0xA5 mask 0xFFF → `cs_out`=0xFFF 16 cycles, `wrst_out` high cycles 5..12, `rsp_valid` cycle 17, `rsp_err`=0.
- Read addr 0x03 mask 0x821, model returns 0x10+ch → visits ch0, ch5, ch11 in order, `rsp_valid` cycle 49, slots 0/5/11 = 0x10/0x15/0x1B, others 0.
- Mask 0 read → `rsp_valid`,`rsp_err` at cycle 1, `cs_out`, strobes stay 0.
- `wb_rst_i` pulsed during STROBE of a read → next cycle all outputs 0, no `rsp_valid`; new write afterward completes in 17 cycles.
- Back-to-back `cmd_valid` held high → second command accepted exactly one cycle after first `rsp_valid`; `unmute_i` toggles mirrored on `unmute_out` one cycle later throughout.
